// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, lane indices and lane count shared by the traffic controller blocks
package traffic_pkg;
  localparam logic [6:0] GREEN_CODE  = 7'b0010000;
  localparam logic [6:0] YELLOW_CODE = 7'b0010001;
  localparam logic [6:0] RED_CODE    = 7'b0101111;
  localparam int LANE_E    = 0;
  localparam int LANE_NL   = 1;
  localparam int LANE_EL   = 2;
  localparam int LANE_W    = 3;
  localparam int NUM_LANES = 4;
endpackage

// File: rtl/lane_debouncer.sv
// lane_debouncer: two-flop synchroniser plus hold-time debounce producing a stable sensor level
module lane_debouncer #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt;
  // accept a new synchronised level only after it has differed from stable for DEB_CYCLES edges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == stable) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= sync_q[1];
        cnt    <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/lane_request_conditioner.sv
// lane_request_conditioner: debounced, green-cleared lane requests; LANE_STARVE_EN adds wait counters and starve flags
module lane_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int WAIT_W       = 8,
  parameter int STARVE_LIMIT = 200
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       raw_E,
  input  logic       raw_NL,
  input  logic       raw_EL,
  input  logic       raw_W,
  input  logic [6:0] ETL,
  input  logic [6:0] NLTL,
  input  logic [6:0] ELTL,
  input  logic [6:0] WTL,
  output logic       E,
  output logic       NL,
  output logic       EL,
  output logic       W,
  output logic [3:0] starve
);
  logic [NUM_LANES-1:0] raw, stable, grant, req;
  assign raw = {raw_W, raw_EL, raw_NL, raw_E};
  assign grant[LANE_E]  = ETL  == GREEN_CODE;
  assign grant[LANE_NL] = NLTL == GREEN_CODE;
  assign grant[LANE_EL] = ELTL == GREEN_CODE;
  assign grant[LANE_W]  = WTL  == GREEN_CODE;
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_deb
    lane_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (Clock),
      .rst_n (Reset_n),
      .raw   (raw[g]),
      .stable(stable[g])
    );
  end
  // latch presence until green is seen; a present vehicle keeps the request alive through green
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) req <= '0;
    else req <= stable | (req & ~grant);
  assign {W, EL, NL, E} = req;
`ifdef LANE_STARVE_EN
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);
  logic [WAIT_W-1:0] wcnt [NUM_LANES];
  // count cycles a latched request goes unserved, saturating, and flag lanes past the limit
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) wcnt[i] <= '0;
      starve <= '0;
    end else
      for (int i = 0; i < NUM_LANES; i++) begin
        wcnt[i]   <= grant[i] ? '0 : (req[i] && wcnt[i] != '1) ? wcnt[i] + WAIT_W'(1) : wcnt[i];
        starve[i] <= wcnt[i] >= LIMIT;
      end
`else
  assign starve = '0;
`endif
endmodule

// File: tb/tb_lane_request_conditioner.sv
// tb_lane_request_conditioner: directed checks of latency, glitch rejection, service clear, starvation and async reset
module tb_lane_request_conditioner;
  import traffic_pkg::*;
`ifdef LANE_STARVE_EN
  localparam logic [3:0] SM = 4'hf;
`else
  localparam logic [3:0] SM = 4'h0;
`endif
  logic Clock = 1'b0, Reset_n;
  logic raw_E, raw_NL, raw_EL, raw_W;
  logic [6:0] ETL, NLTL, ELTL, WTL;
  logic E, NL, EL, W;
  logic [3:0] starve;
  int vectors = 0, errs = 0;

  lane_request_conditioner dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .raw_E(raw_E), .raw_NL(raw_NL), .raw_EL(raw_EL), .raw_W(raw_W),
    .ETL(ETL), .NLTL(NLTL), .ELTL(ELTL), .WTL(WTL),
    .E(E), .NL(NL), .EL(EL), .W(W), .starve(starve)
  );

  always #5 Clock = ~Clock;

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    {raw_W, raw_EL, raw_NL, raw_E} = '0;
    {ETL, NLTL, ELTL, WTL} = {RED_CODE, RED_CODE, RED_CODE, RED_CODE};
    tick(3);
    chk("reset_req", {W, EL, NL, E}, 4'b0000);
    chk("reset_starve", starve, 4'b0000);
    Reset_n = 1'b1;
    tick(1);
    raw_E = 1'b1;
    tick(6);
    chk("lat_before", {W, EL, NL, E}, 4'b0000);
    tick(1);
    chk("lat_after", {W, EL, NL, E}, 4'b0001);
    raw_W = 1'b1;
    tick(3);
    raw_W = 1'b0;
    tick(10);
    chk("glitch1", {W, EL, NL, E}, 4'b0001);
    raw_W = 1'b1;
    tick(3);
    raw_W = 1'b0;
    tick(10);
    chk("glitch2", {W, EL, NL, E}, 4'b0001);
    raw_W = 1'b1;
    tick(6);
    raw_W = 1'b0;
    tick(10);
    chk("pulse6_held", {W, EL, NL, E}, 4'b1001);
    WTL = GREEN_CODE;
    tick(1);
    WTL = RED_CODE;
    chk("w_served", {W, EL, NL, E}, 4'b0001);
    raw_NL = 1'b1;
    tick(7);
    chk("nl_rise", {W, EL, NL, E}, 4'b0011);
    NLTL = GREEN_CODE;
    tick(3);
    chk("nl_green_present", {W, EL, NL, E}, 4'b0011);
    NLTL = RED_CODE;
    raw_NL = 1'b0;
    tick(8);
    chk("nl_latched", {W, EL, NL, E}, 4'b0011);
    NLTL = GREEN_CODE;
    tick(1);
    NLTL = RED_CODE;
    chk("nl_served", {W, EL, NL, E}, 4'b0001);
    raw_E = 1'b0;
    tick(8);
    ETL = GREEN_CODE;
    tick(1);
    ETL = RED_CODE;
    chk("e_served", {W, EL, NL, E}, 4'b0000);
    chk("no_starve_yet", starve, 4'b0000);
    raw_EL = 1'b1;
    tick(7);
    raw_EL = 1'b0;
    chk("el_rise", {W, EL, NL, E}, 4'b0100);
    tick(200);
    chk("starve_200", starve, 4'b0000);
    tick(1);
    chk("starve_201", starve, 4'b0100 & SM);
    tick(100);
    chk("starve_sat", starve, 4'b0100 & SM);
    chk("el_hold", {W, EL, NL, E}, 4'b0100);
    ELTL = GREEN_CODE;
    tick(1);
    ELTL = RED_CODE;
    chk("el_served", {W, EL, NL, E}, 4'b0000);
    chk("starve_lag", starve, 4'b0100 & SM);
    tick(1);
    chk("starve_clear", starve, 4'b0000);
    raw_E = 1'b1;
    tick(7);
    chk("e_again", {W, EL, NL, E}, 4'b0001);
    tick(201);
    chk("starve_e", starve, 4'b0001 & SM);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_req", {W, EL, NL, E}, 4'b0000);
    chk("async_starve", starve, 4'b0000);
    raw_E = 1'b0;
    tick(2);
    Reset_n = 1'b1;
    tick(10);
    chk("post_reset", {W, EL, NL, E}, 4'b0000);
    chk("post_reset_starve", starve, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
